// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//
// Coefficient source for the transposed FIR chain. The host fills a shadow
// bank of NUM_TAP signed coefficients through a chip-select / write-strobe
// interface and can read it back. An update request arms a copy of the shadow
// bank into the active bank. The copy starts on the next sample strobe and
// moves one tap per clock, so it finishes well before the following strobe.
// The filter therefore never sees a half-loaded set within a sample.
//
// Optional build macro:
//   COEFF_SYM_EN - symmetric-filter mode. A write to tap k also writes
//                  tap NUM_TAP-1-k with the same data.
//
// Ports:
//   iClk_12M        system clock
//   iRsn            asynchronous active-low reset
//   iEnSample_300k  one-clock sample strobe
//   iCsn, iWrn      host chip select / write strobe (active-low; iWrn=1 reads)
//   iAddr, iWrDt    host tap index / write data
//   oRdDt, oRdDtVld host read data and its one-clock valid (latency 1)
//   iUpdate         request a shadow-to-active copy (pulse)
//   oBusy           high while an update is armed, copying or completing
//   oCoeffBus       active bank; tap k at bits [k*COEFF_W +: COEFF_W]
//   oCoeffVld       one-clock pulse when a new active set is complete
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fir_coeff_loader #(
  parameter int NUM_TAP = 12,
  parameter int COEFF_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       iEnSample_300k,
  input  logic                       iCsn,
  input  logic                       iWrn,
  input  logic [ADDR_W-1:0]          iAddr,
  input  logic [COEFF_W-1:0]         iWrDt,
  output logic [COEFF_W-1:0]         oRdDt,
  output logic                       oRdDtVld,
  input  logic                       iUpdate,
  output logic                       oBusy,
  output logic [NUM_TAP*COEFF_W-1:0] oCoeffBus,
  output logic                       oCoeffVld
);

  localparam int                IDX_W    = (NUM_TAP > 1) ? $clog2(NUM_TAP) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COPY,
    ST_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;

  logic [COEFF_W-1:0]   shadow [NUM_TAP];
  logic [COEFF_W-1:0]   active [NUM_TAP];

  logic                 wr_req;
  logic                 rd_req;
  logic [NUM_TAP-1:0]   wr_hit;
  logic [COEFF_W-1:0]   rd_mux;

  // Host writes are accepted only in IDLE so the shadow bank stays frozen
  // from the update request until the copy has finished.
  assign wr_req = !iCsn && !iWrn && (state == ST_IDLE);
  assign rd_req = !iCsn &&  iWrn;

  // Per-tap write decode. Out-of-range addresses match no tap and are dropped.
  for (genvar i = 0; i < NUM_TAP; i++) begin : g_wr_hit
`ifdef COEFF_SYM_EN
    // The mirror term coincides with the direct term at the centre tap,
    // which then simply takes a single write.
    assign wr_hit[i] = wr_req && ((iAddr == ADDR_W'(i)) ||
                                  (iAddr == ADDR_W'(NUM_TAP - 1 - i)));
`else
    assign wr_hit[i] = wr_req && (iAddr == ADDR_W'(i));
`endif
  end

  // ---------------------------------------------------------------------------
  // Update FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    unique case (state)
      // A strobe coinciding with iUpdate is ignored here: the copy waits for
      // the next strobe seen from ARM.
      ST_IDLE: if (iUpdate)            state_nxt = ST_ARM;
      ST_ARM:  if (iEnSample_300k)     state_nxt = ST_COPY;
      ST_COPY: if (idx == LAST_IDX)    state_nxt = ST_DONE;
      ST_DONE:                         state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // oBusy and oCoeffVld are registered from the next state so they line up
  // exactly with the state they describe, without a combinational path out.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state     <= ST_IDLE;
      oBusy     <= 1'b0;
      oCoeffVld <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state     <= state_nxt;
      oBusy     <= (state_nxt != ST_IDLE);
      oCoeffVld <= (state_nxt == ST_DONE);
    end
  end

  // Copy index: held at 0 while armed, then walks 0..NUM_TAP-1 during COPY.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      idx <= '0;
    end else if (state == ST_ARM) begin
      idx <= '0;
    end else if (state == ST_COPY) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient banks
  // ---------------------------------------------------------------------------
  // NOTE: both banks are cleared by reset because a reset must leave the
  // filter with known all-zero coefficients; that rules out RAM inference,
  // which is acceptable for a bank this small.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NUM_TAP; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TAP; i++) begin
        if (wr_hit[i]) begin
          shadow[i] <= iWrDt;
        end
      end
    end
  end

  // One tap per clock; a reset mid-copy discards the partial set.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NUM_TAP; i++) begin
        active[i] <= '0;
      end
    end else if (state == ST_COPY) begin
      active[idx] <= shadow[idx];
    end
  end

  for (genvar k = 0; k < NUM_TAP; k++) begin : g_bus
    assign oCoeffBus[k*COEFF_W +: COEFF_W] = active[k];
  end

  // ---------------------------------------------------------------------------
  // Host readback
  // ---------------------------------------------------------------------------
  // Out-of-range addresses match no tap and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TAP; i++) begin
      if (iAddr == ADDR_W'(i)) begin
        rd_mux = shadow[i];
      end
    end
  end

  // oRdDt holds its last value between reads; only the valid flag pulses.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oRdDt    <= '0;
      oRdDtVld <= 1'b0;
    end else begin
      oRdDtVld <= rd_req;
      if (rd_req) begin
        oRdDt <= rd_mux;
      end
    end
  end

endmodule
